// File: rtl/lsu.sv
// MEM-stage load/store unit: one single-beat req/ready bus transaction per load/store,
// with byte-lane alignment of store data, load extraction/extension and fault reporting.
module lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        access_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  count_reg;
    logic        we_reg, uns_reg, err_reg, timeout_reg, bus_req_reg;
    logic [1:0]  size_reg, off_reg;
    logic [31:0] bus_addr_reg, wdata_reg, rdata_reg, load_data_reg;
    logic [3:0]  be_reg;

    logic        req, illegal, start, last_wait;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc, load_ext;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign req       = mem_read | mem_write;
    assign illegal   = (mem_size == 2'b11) || (mem_read && mem_write) ||
                       (mem_size == 2'b01 && addr[0]) ||
                       (mem_size == 2'b10 && addr[1:0] != 2'b00);
    assign last_wait = (count_reg == 8'(TIMEOUT_CYCLES - 1));

    always_comb begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        case (mem_size)
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Extraction works from the captured word and the latched offset/size, so the
    // result is independent of whatever the pipeline presents during DONE.
    assign byte_sel = rdata_reg[8*off_reg +: 8];
    assign half_sel = rdata_reg[16*off_reg[1] +: 16];

    always_comb begin
        load_ext = rdata_reg;
        case (size_reg)
            2'b00:   load_ext = {{24{byte_sel[7] & ~uns_reg}}, byte_sel};
            2'b01:   load_ext = {{16{half_sel[15] & ~uns_reg}}, half_sel};
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        stall      = 1'b0;
        access_err = 1'b0;
        load_valid = 1'b0;
        start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req && !flush) begin
                    if (illegal) begin
                        access_err = 1'b1;
                    end else begin
                        start      = 1'b1;
                        stall      = 1'b1;
                        state_next = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (bus_ready || last_wait) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
                if (err_reg || timeout_reg) access_err = 1'b1;
                else if (!we_reg && !flush)  load_valid = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg     <= '0;
            we_reg        <= 1'b0;
            uns_reg       <= 1'b0;
            err_reg       <= 1'b0;
            timeout_reg   <= 1'b0;
            bus_req_reg   <= 1'b0;
            size_reg      <= '0;
            off_reg       <= '0;
            bus_addr_reg  <= '0;
            wdata_reg     <= '0;
            rdata_reg     <= '0;
            load_data_reg <= '0;
            be_reg        <= '0;
        end else begin
            if (start) begin
                we_reg       <= mem_write;
                uns_reg      <= mem_unsigned;
                size_reg     <= mem_size;
                off_reg      <= addr[1:0];
                bus_addr_reg <= {addr[31:2], 2'b00};
                be_reg       <= be_calc;
                wdata_reg    <= wdata_calc;
                count_reg    <= '0;
                err_reg      <= 1'b0;
                timeout_reg  <= 1'b0;
                bus_req_reg  <= 1'b1;
            end
            if (state_reg == ACCESS) begin
                if (bus_ready) begin
                    rdata_reg   <= bus_rdata;
                    err_reg     <= bus_err;
                    bus_req_reg <= 1'b0;
                end else if (last_wait) begin
                    timeout_reg <= 1'b1;
                    bus_req_reg <= 1'b0;
                end else begin
                    count_reg <= count_reg + 8'd1;
                end
            end
            if (load_valid) load_data_reg <= load_ext;
        end
    end

    assign load_data = load_valid ? load_ext : load_data_reg;
    assign bus_req   = bus_req_reg;
    assign bus_we    = we_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_be    = be_reg;
    assign bus_wdata = wdata_reg;
endmodule

// File: tb/tb_lsu.sv
// Randomized and directed bench for lsu against a behavioural transaction model.
module tb_lsu;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_unsigned = 1'b0;
    logic [1:0]  mem_size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, load_valid, access_err, bus_req, bus_we;
    logic [31:0] load_data, bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_load = '0;

    lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .access_err(access_err), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_be(input logic [1:0] sz, input int off);
        if (sz == 2'd0) return 4'(1 << off);
        if (sz == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic un,
                                               input int off, input logic [31:0] w);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * off)) & 32'hFF;
            if (!un && v >= 32'd128) v = v - 32'd256;
            return v;
        end
        if (sz == 2'd1) begin
            v = (w >> (16 * (off / 2))) & 32'hFFFF;
            if (!un && v >= 32'd32768) v = v - 32'd65536;
            return v;
        end
        return w;
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        mem_read = 0; mem_write = 0; flush = 0; bus_ready = 0;
        #1;
        check_val("idle_stall", stall, 0);
        check_val("idle_req", bus_req, 0);
        check_val("idle_err", access_err, 0);
        check_val("idle_lv", load_valid, 0);
        check_val("idle_hold", load_data, last_load);
    endtask

    task automatic txn(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                       input logic [31:0] a, input logic [31:0] wd, input int wt,
                       input logic er, input logic [31:0] word, input logic fl_done);
        int  off, k;
        bit  legal, fin, rdy, exp_err, exp_lv;
        logic [31:0] exp_ld;
        off   = int'(a[1:0]);
        legal = (sz != 2'd3) && !(rd && wr) && !(sz == 2'd1 && off % 2 != 0) &&
                !(sz == 2'd2 && off != 0);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = un;
        addr = a; wdata = wd; flush = 0; bus_ready = 0;
        #1;
        if (!legal) begin
            check_val("ill_err", access_err, 1);
            check_val("ill_stall", stall, 0);
            @(posedge clk); #1;
            check_val("ill_noreq", bus_req, 0);
            mem_read = 0; mem_write = 0;
            return;
        end
        check_val("start_stall", stall, 1);
        check_val("start_err", access_err, 0);
        k = 0; fin = 0; rdy = 0;
        while (!fin) begin
            @(posedge clk); #1;
            flush     = 1'($urandom_range(0, 1));
            rdy       = (k == wt);
            bus_ready = rdy;
            bus_err   = rdy ? er : 1'($urandom_range(0, 1));
            bus_rdata = rdy ? word : $urandom;
            #1;
            check_val("acc_req", bus_req, 1);
            check_val("acc_stall", stall, 1);
            if (k == 0) begin
                check_val("acc_we", bus_we, wr);
                check_val("acc_addr", bus_addr, a & 32'hFFFF_FFFC);
                check_val("acc_be", bus_be, model_be(sz, off));
                if (wr) check_val("acc_wdata", bus_wdata, model_wdata(sz, wd));
            end
            if (rdy || k == TO - 1) fin = 1;
            k++;
        end
        exp_err = !rdy || er;
        exp_lv  = !exp_err && rd && !fl_done;
        exp_ld  = model_load(sz, un, off, word);
        @(posedge clk); #1;
        bus_ready = 0; flush = fl_done;
        #1;
        check_val("done_stall", stall, 0);
        check_val("done_req", bus_req, 0);
        check_val("done_err", access_err, exp_err);
        check_val("done_lv", load_valid, exp_lv);
        if (exp_lv) last_load = exp_ld;
        check_val("done_data", load_data, last_load);
        $display("txn rd=%0b wr=%0b sz=%0d un=%0b a=%h wt=%0d err=%0b fl=%0b", rd, wr, sz, un, a, wt, er, fl_done);
    endtask

    initial begin
        #12;
        check_val("rst_stall", stall, 0);
        check_val("rst_req", bus_req, 0);
        check_val("rst_err", access_err, 0);
        check_val("rst_lv", load_valid, 0);
        check_val("rst_data", load_data, 0);
        check_val("rst_be", {28'd0, bus_be}, 0);
        rst_n = 1;

        // Directed cases
        txn(1, 0, 2'd2, 0, 32'h100, 0, 0, 0, 32'hDEADBEEF, 0);
        txn(1, 0, 2'd0, 0, 32'h103, 0, 0, 0, 32'h80FF_0000, 0);
        check_val("lb_val", last_load, 32'hFFFF_FF80);
        txn(1, 0, 2'd0, 1, 32'h103, 0, 1, 0, 32'h80FF_0000, 0);
        check_val("lbu_val", last_load, 32'h0000_0080);
        txn(0, 1, 2'd1, 0, 32'h22, 32'h1234ABCD, 0, 0, 0, 0);
        txn(1, 0, 2'd2, 0, 32'h102, 0, 0, 0, 0, 0);
        txn(1, 0, 2'd2, 0, 32'h200, 0, 9, 0, 0, 0);
        idle_cycle();
        txn(1, 0, 2'd1, 0, 32'h302, 0, 2, 1, 32'h8001_0000, 0);
        txn(1, 0, 2'd1, 0, 32'h302, 0, 0, 0, 32'h8001_0000, 1);

        // Flushed request in IDLE never starts
        @(posedge clk); #1;
        mem_read = 1; mem_write = 0; mem_size = 2'd2; addr = 32'h40; flush = 1;
        #1;
        check_val("fl_stall", stall, 0);
        check_val("fl_err", access_err, 0);
        @(posedge clk); #1;
        mem_read = 0; flush = 0;
        #1;
        check_val("fl_noreq", bus_req, 0);

        for (int n = 0; n < 200; n++) begin
            logic rd, wr;
            int   r;
            r  = $urandom_range(0, 15);
            rd = (r < 8) || (r == 15);
            wr = (r >= 8);
            txn(rd, wr, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom_range(0, 5),
                ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Reset in the middle of an access
        @(posedge clk); #1;
        mem_read = 1; mem_write = 0; mem_size = 2'd2; addr = 32'h500; flush = 0;
        @(posedge clk); #1;
        check_val("mid_req", bus_req, 1);
        rst_n = 0;
        #1;
        check_val("mid_rst_req", bus_req, 0);
        mem_read = 0;
        @(posedge clk); #1;
        rst_n = 1;
        last_load = 0;
        @(posedge clk); #1;
        check_val("post_stall", stall, 0);
        check_val("post_req", bus_req, 0);
        check_val("post_err", access_err, 0);
        check_val("post_lv", load_valid, 0);
        check_val("post_data", load_data, 0);
        check_val("post_addr", bus_addr, 0);
        check_val("post_be", {28'd0, bus_be}, 0);
        check_val("post_we", bus_we, 0);
        txn(1, 0, 2'd0, 0, 32'h601, 0, 0, 0, 32'h0000_7F00, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
